// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM state encoding (2 bits) and
//                frame constants, reused by uart_tx and a future uart_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Line FSM states; encoding is shared with the receiver.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // 8N1 framing: 8 data bits plus one start and one stop bit.
    localparam int c_DATA_BITS  = 8;
    localparam int c_FRAME_BITS = 10;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Small synchronous FIFO with show-ahead read data.
//                Pushes while full and pops while empty are ignored.
//  Ports       : clk      - clock, rising edge
//                reset    - synchronous active-low reset (clears pointers)
//                i_push   - write i_data this edge (ignored when full)
//                i_pop    - drop head entry this edge (ignored when empty)
//                i_data   - write data
//                o_data   - head entry (valid while !o_empty)
//                o_full   - no free entries
//                o_empty  - no stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("uart_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_full  = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // Storage needs no reset; emptiness is governed by the count alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : uart_fifo
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART transmitter with a small input FIFO. Frames are
//                sent back to back while bytes remain queued.
//  Ports       : clk      - clock, rising edge
//                reset    - synchronous active-low reset
//                tx_data  - byte to send, taken when tx_valid && tx_ready
//                tx_valid - tx_data holds a byte
//                tx_ready - FIFO can accept a byte this cycle
//                TXD      - registered serial line, idle high
//                busy     - frame in progress or bytes queued
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 27_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TXD,
    output logic       busy
);

    localparam int c_DIVISOR = CLK_FREQ_HZ / BAUD_RATE;
    localparam int c_BAUD_W  = (c_DIVISOR < 2) ? 1 : $clog2(c_DIVISOR);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_DIVISOR - 1);
    localparam logic [2:0]          c_LAST_BIT  = 3'(c_DATA_BITS - 1);

    generate
        if (c_DIVISOR < 2) begin : g_divisor_check
            $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
        end
        if (c_FRAME_BITS != c_DATA_BITS + 2) begin : g_frame_check
            $error("uart_tx: frame must be start + data bits + one stop bit");
        end
    endgenerate

    uart_state_t         r_state;
    uart_state_t         w_state_n;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [c_BAUD_W-1:0] w_baud_cnt_n;
    logic [2:0]          r_bit_cnt;
    logic [2:0]          w_bit_cnt_n;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_n;
    logic                r_txd;
    logic                w_txd_n;
    logic                r_ready;

    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_fifo_data;
    logic       w_bit_end;

    // r_ready keeps the input closed while reset is held and opens on the
    // first edge after release.
    assign tx_ready  = r_ready && !w_full;
    assign w_push    = tx_valid && tx_ready;
    assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);

    assign TXD  = r_txd;
    assign busy = (r_state != IDLE) || !w_empty;

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (tx_data),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_n    = r_state;
        w_baud_cnt_n = r_baud_cnt;
        w_bit_cnt_n  = r_bit_cnt;
        w_shift_n    = r_shift;
        w_txd_n      = r_txd;
        w_pop        = 1'b0;

        // Baud counter free-runs through every bit of a frame and wraps at
        // the end of each bit period, so chained frames stay aligned.
        if (r_state != IDLE) begin
            w_baud_cnt_n = w_bit_end ? '0 : r_baud_cnt + c_BAUD_W'(1);
        end

        case (r_state)
            IDLE: begin
                w_baud_cnt_n = '0;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_fifo_data;
                    w_txd_n   = 1'b0;
                    w_state_n = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_bit_cnt_n = '0;
                    w_txd_n     = r_shift[0];
                    w_state_n   = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_txd_n   = 1'b1;
                        w_state_n = STOP;
                    end else begin
                        // Next data bit is the one just above the current LSB.
                        w_bit_cnt_n = r_bit_cnt + 3'd1;
                        w_shift_n   = {1'b0, r_shift[7:1]};
                        w_txd_n     = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shift_n = w_fifo_data;
                        w_txd_n   = 1'b0;
                        w_state_n = START;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
            end
            default: begin
                w_txd_n   = 1'b1;
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_baud_cnt <= w_baud_cnt_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_shift    <= w_shift_n;
            r_txd      <= w_txd_n;
            r_ready    <= 1'b1;
        end
    end

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx (DIVISOR = 4). A line
//                decoder turns TXD back into bytes with frame start times.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 250_000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int FRAME  = c_FRAME_BITS * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       TXD;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    uart_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .TXD      (TXD),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Line decoder: every bit must hold for DIV samples; frames are FRAME long.
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    int         glitch_cnt = 0;
    int         frame_err  = 0;
    bit         dec_act = 1'b0;
    int         dec_k = 0;
    int         dec_start = 0;
    logic [9:0] dec_bits = '0;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            dec_act = 1'b0;
        end else if (!dec_act) begin
            if (TXD === 1'b0) begin
                dec_act     = 1'b1;
                dec_k       = 0;
                dec_start   = cyc_cnt;
                dec_bits[0] = 1'b0;
            end
        end else begin
            dec_k = dec_k + 1;
            if (dec_k % DIV == 0) dec_bits[dec_k / DIV] = TXD;
            else if (TXD !== dec_bits[dec_k / DIV]) glitch_cnt++;
            if (dec_k == FRAME - 1) begin
                if (dec_bits[9] !== 1'b1) frame_err++;
                rx_q.push_back(dec_bits[8:1]);
                rx_start_q.push_back(dec_start);
                dec_act = 1'b0;
            end
        end
    end

    task automatic wait_until(input int e);
        while (cyc_cnt < e) @(negedge clk);
    endtask

    // Called at a negedge; holds tx_valid until accepted. acc_edge is the
    // number of the clock edge that took the byte.
    task automatic send_byte(input logic [7:0] b, output int acc_edge);
        bit ok;
        ok = 1'b0;
        acc_edge = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (tx_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc_edge = cyc_cnt;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: byte %02h not accepted, required acceptance within 400 cycles", b);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", TXD); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b expected 0", tx_ready); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise: got %b expected 1", tx_ready); end
        n_checks++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL reset_txd_idle: got %b expected 1", TXD); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single;
        int acc;
        rx_q.delete(); rx_start_q.delete();
        send_byte(8'h55, acc);
        n_checks++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL single_txd_n: got %b expected 1", TXD); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_n: got %b expected 1", busy); end
        @(negedge clk);
        n_checks++; if (TXD !== 1'b0) begin n_fail++; $display("FAIL single_start_n1: got %b expected 0", TXD); end
        wait_until(acc + FRAME);
        n_checks++; if (busy !== 1'b1 || TXD !== 1'b1) begin n_fail++; $display("FAIL single_stop_last: busy %b txd %b expected 1 1", busy, TXD); end
        wait_until(acc + FRAME + 1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
        n_checks++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d frames expected 1", rx_q.size()); end
        else begin
            n_checks++; if (rx_q[0] !== 8'h55) begin n_fail++; $display("FAIL single_byte: got %02h expected 55", rx_q[0]); end
            n_checks++; if (rx_start_q[0] != acc + 1) begin n_fail++; $display("FAIL single_latency: start %0d expected %0d", rx_start_q[0], acc + 1); end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int a0, a1;
        rx_q.delete(); rx_start_q.delete();
        send_byte(8'hA5, a0);
        send_byte(8'h3C, a1);
        n_checks++; if (a1 != a0 + 1) begin n_fail++; $display("FAIL b2b_accept: second at %0d expected %0d", a1, a0 + 1); end
        wait_until(a0 + 2 * FRAME + 3);
        n_checks++; if (rx_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", rx_q.size()); end
        else begin
            n_checks++; if (rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C) begin n_fail++; $display("FAIL b2b_bytes: got %02h %02h expected a5 3c", rx_q[0], rx_q[1]); end
            n_checks++; if (rx_start_q[1] - rx_start_q[0] != FRAME) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles expected %0d", rx_start_q[1] - rx_start_q[0], FRAME); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b expected 0", busy); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_full_fifo;
        int acc[6];
        rx_q.delete(); rx_start_q.delete();
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1), acc[i]);
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", tx_ready); end
        n_checks++; if (acc[4] != acc[0] + 4) begin n_fail++; $display("FAIL full_fill: 5th at %0d expected %0d", acc[4], acc[0] + 4); end
        send_byte(8'h06, acc[5]);
        // First pop after filling is the end of frame one; being full there,
        // 0x06 is taken on the edge after it.
        n_checks++; if (acc[5] != acc[0] + FRAME + 2) begin n_fail++; $display("FAIL full_wait: 6th at %0d expected %0d", acc[5], acc[0] + FRAME + 2); end
        wait_until(acc[0] + 6 * FRAME + 3);
        n_checks++; if (rx_q.size() != 6) begin n_fail++; $display("FAIL full_count: got %0d expected 6", rx_q.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (rx_q[i] !== 8'(i + 1) || rx_start_q[i] != acc[0] + 1 + i * FRAME) begin
                    n_fail++;
                    $display("FAIL full_frame%0d: got %02h at %0d expected %02h at %0d", i, rx_q[i], rx_start_q[i], i + 1, acc[0] + 1 + i * FRAME);
                end
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_valid_while_full;
        int acc;
        int a0;
        int bad;
        rx_q.delete(); rx_start_q.delete();
        send_byte(8'h10, a0);
        for (int i = 1; i < 5; i++) send_byte(8'(8'h10 + i), acc);
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL blocked_ready: got %b expected 0", tx_ready); end
        tx_data = 8'h99; tx_valid = 1'b1;
        repeat (10) @(negedge clk);
        tx_valid = 1'b0;
        wait_until(a0 + 5 * FRAME + 3);
        bad = 0;
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] === 8'h99 || rx_q[i] !== 8'(8'h10 + i)) bad++;
        n_checks++; if (rx_q.size() != 5 || bad != 0) begin n_fail++; $display("FAIL blocked_stream: got %0d frames %0d wrong expected 5 frames 0 wrong", rx_q.size(), bad); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        int a0, a1, s;
        rx_q.delete(); rx_start_q.delete();
        send_byte(8'hFF, a0);
        send_byte(8'h11, a1);
        send_byte(8'h22, a1);
        s = a0 + 1;
        wait_until(s + 4 * DIV + 1);   // inside data bit 3
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL midrst_txd: got %b expected 1", TXD); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", tx_ready); end
        reset = 1'b1;
        repeat (4 * FRAME) @(negedge clk);
        n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL midrst_nothing_sent: got %0d frames expected 0", rx_q.size()); end
        n_checks++; if (TXD !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: txd %b busy %b ready %b expected 1 0 1", TXD, busy, tx_ready); end
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int acc, bad, g0, f0;
        rx_q.delete(); rx_start_q.delete();
        g0 = glitch_cnt; f0 = frame_err;
        for (int i = 0; i < 200; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_byte(b, acc);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
        end
        for (int i = 0; i < 20000 && rx_q.size() < 200; i++) @(negedge clk);
        n_checks++; if (rx_q.size() != 200) begin n_fail++; $display("FAIL random_count: got %0d expected 200", rx_q.size()); end
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < 200; i++) if (rx_q[i] !== exp_q[i]) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL random_bytes: got %0d wrong bytes expected 0", bad); end
        n_checks++; if (glitch_cnt != g0 || frame_err != f0) begin n_fail++; $display("FAIL random_timing: got %0d bit-period and %0d stop errors expected 0", glitch_cnt - g0, frame_err - f0); end
        repeat (2 * FRAME) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || TXD !== 1'b1) begin n_fail++; $display("FAIL random_idle: busy %b txd %b expected 0 1", busy, TXD); end
        n_checks++; if (glitch_cnt != 0 || frame_err != 0) begin n_fail++; $display("FAIL line_timing_total: got %0d/%0d errors expected 0", glitch_cnt, frame_err); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_full_fifo();
        test_valid_while_full();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not complete, required completion before 800000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_tx
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 27_000_000: frequency of clk in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200: serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: bytes buffered; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low; 0 = reset, sampled on the clk rising edge.
REQ-006 SHALL have port tx_data, input, 8: byte to send; sampled when tx_valid && tx_ready.
REQ-007 SHALL have port tx_valid, input, 1: tx_data holds a byte for transfer.
REQ-008 SHALL have port tx_ready, output, 1: FIFO can accept a byte this cycle.
REQ-009 SHALL have port TXD, output, 1: serial line, idle high.
REQ-010 SHALL have port busy, output, 1: frame in progress or FIFO non-empty.

Function
REQ-011 SHALL use DIVISOR = CLK_FREQ_HZ / BAUD_RATE (integer division); elaboration fails if DIVISOR < 2.
REQ-012 SHALL size the baud counter at $clog2(DIVISOR) bits and wrap it from DIVISOR-1 to 0; each bit holds TXD for exactly DIVISOR clk cycles.
REQ-013 SHALL send 8N1 frames: start bit (0), data bits 0 to 7 LSB first, one stop bit (1); frame length 10*DIVISOR cycles.
REQ-014 SHALL write tx_data into the FIFO on every edge where tx_valid && tx_ready; no other input condition writes it.
REQ-015 SHALL drive tx_ready = !full; when full, tx_valid is ignored, even if a pop happens on the same edge.
REQ-016 SHALL allow a push and a pop on the same edge when not full; the count is unchanged.
REQ-017 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-018 SHALL make IDLE transition to START on the first edge where the FIFO is non-empty; that edge pops one byte into the shift register and sets TXD to 0.
REQ-019 SHALL make START transition to DATA after DIVISOR cycles; DATA shifts right once per bit period.
REQ-020 SHALL make DATA transition to STOP after 8 bit periods; a 3-bit counter tracks the bit index.
REQ-021 SHALL make STOP exit after DIVISOR cycles: to START with a pop on the same edge if the FIFO is non-empty, otherwise to IDLE.
REQ-022 SHALL have a latency of one cycle: a byte accepted at edge N into an empty FIFO with the FSM in IDLE gives TXD = 0 from edge N+1.
REQ-023 SHALL produce back-to-back frames with no extra idle cycles between a stop bit and the next start bit.
REQ-024 SHALL register TXD, driven directly from a flop with no glitches.
REQ-025 SHALL drive busy = (state != IDLE) || !empty.

Reset
REQ-026 SHALL, on any edge with reset = 0, set: state to IDLE, TXD to 1, FIFO pointers and count to 0, counters to 0, busy to 0.
REQ-027 SHALL hold tx_ready at 0 while reset = 0 and set it to 1 on the first edge after reset returns to 1.
REQ-028 SHALL, when reset is asserted mid-frame, abort the frame: TXD is 1 from that edge, queued bytes are discarded and never transmitted.

Structure
REQ-029 SHALL place FSM state encodings (2 bits) and frame constants (data bits = 8, frame bits = 10) in a shared include file for use by a later uart_rx.
REQ-030 SHALL implement the FIFO as sub-module uart_fifo (parameters WIDTH and DEPTH; push, pop, full, empty; synchronous active-low reset).
REQ-031 SHALL keep the baud counter, bit counter, shift register and FSM in uart_tx.

Verification (CLK_FREQ_HZ=1_000_000, BAUD_RATE=250_000, so DIVISOR=4)
REQ-032 SHALL cover a single byte: send 0x55 from idle -> TXD = 1 -> 0 at N+1, then bits 1,0,1,0,1,0,1,0, then stop bit 1, each for 4 cycles; busy falls after 40 cycles.
REQ-033 SHALL cover back-to-back bytes: 0xA5 and 0x3C sent on consecutive cycles -> two 40-cycle frames with the second start bit immediately after the first stop bit.
REQ-034 SHALL cover the full FIFO: 6 bytes 0x01 to 0x06 presented with tx_valid held -> 0x01 pops, 0x02 to 0x05 fill the FIFO, tx_ready = 0, 0x06 waits; 0x06 is accepted at the next pop and all 6 bytes are sent in order.
REQ-035 SHALL cover reset mid-frame: reset = 0 during data bit 3 of 0xFF with 2 bytes queued -> TXD = 1 next edge, busy = 0, nothing further sent.
REQ-036 SHALL cover tx_valid while tx_ready = 0: present 0x99 while full -> 0x99 never appears on TXD.
REQ-037 SHALL cover random traffic: 200 random bytes with random tx_valid gaps, checked by a bench UART decoder -> byte stream identical and every bit period exactly 4 cycles.
